// File: rtl/input_mem_loader_if.sv
// input_mem_loader_if: control, pixel-stream and memory-write signals of the input loader.
interface input_mem_loader_if #(
   parameter int ADD_SIZE  = 12,
   parameter int DATA_SIZE = 108
);
   logic                 start;
   logic                 abort;
   logic [ADD_SIZE-1:0]  base_addr;
   logic [ADD_SIZE:0]    num_words;
   logic                 s_valid;
   logic [DATA_SIZE-1:0] s_data;
   logic                 s_ready;
   logic                 write_en;
   logic                 in_valid;
   logic [ADD_SIZE-1:0]  address_in;
   logic [DATA_SIZE-1:0] dataIn;
   logic                 out_ready;
   logic                 busy;
   logic                 done;
   modport master (
      output start, abort, base_addr, num_words, s_valid, s_data, out_ready,
      input  s_ready, write_en, in_valid, address_in, dataIn, busy, done
   );
   modport slave (
      input  start, abort, base_addr, num_words, s_valid, s_data, out_ready,
      output s_ready, write_en, in_valid, address_in, dataIn, busy, done
   );
endinterface

// File: rtl/input_mem_loader.sv
// input_mem_loader: moves num_words stream words into write_mem_controller
// at consecutive (wrapping) addresses from base_addr, one holding register deep.
module input_mem_loader #(
   parameter int ADD_SIZE  = 12,
   parameter int DATA_SIZE = 108
) (
   input logic               clk,
   input logic               rst,
   input_mem_loader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   localparam logic [ADD_SIZE:0]   CNT_ONE  = 1;
   localparam logic [ADD_SIZE-1:0] ADDR_ONE = 1;
   state_t               state_q;
   logic [ADD_SIZE-1:0]  addr_q;
   logic [ADD_SIZE-1:0]  address_q;
   logic [ADD_SIZE:0]    fetch_q;
   logic [ADD_SIZE:0]    wr_q;
   logic [DATA_SIZE-1:0] data_q;
   logic                 in_valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 s_acc;
   logic                 w_acc;
   logic                 last_wr;
   assign bus.s_ready    = (state_q == LOAD) && (fetch_q != '0) && (!in_valid_q || bus.out_ready);
   assign s_acc          = bus.s_valid & bus.s_ready;
   assign w_acc          = in_valid_q & bus.out_ready;
   assign last_wr        = w_acc && (wr_q == CNT_ONE);
   assign bus.write_en   = in_valid_q;
   assign bus.in_valid   = in_valid_q;
   assign bus.address_in = address_q;
   assign bus.dataIn     = data_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         address_q  <= '0;
         fetch_q    <= '0;
         wr_q       <= '0;
         data_q     <= '0;
         in_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (bus.abort && state_q != IDLE) begin
         state_q    <= IDLE;
         in_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  addr_q  <= bus.base_addr;
                  fetch_q <= bus.num_words;
                  wr_q    <= bus.num_words;
                  state_q <= (bus.num_words == '0) ? DONE : LOAD;
                  busy_q  <= (bus.num_words != '0);
                  done_q  <= (bus.num_words == '0);
               end
            end
            LOAD, DRAIN: begin
               if (s_acc) begin
                  address_q  <= addr_q;
                  data_q     <= bus.s_data;
                  in_valid_q <= 1'b1;
                  addr_q     <= addr_q + ADDR_ONE;
                  fetch_q    <= fetch_q - CNT_ONE;
               end else if (w_acc) begin
                  in_valid_q <= 1'b0;
               end
               if (w_acc)
                  wr_q <= wr_q - CNT_ONE;
               // the final write can retire the cycle the fetch count is already spent, skipping DRAIN
               if (last_wr) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (fetch_q == '0) begin
                  state_q <= DRAIN;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/input_mem_loader.md
# input_mem_loader

Sequencer that fills the image-accelerator input memory from a streaming pixel source. On `start` it accepts `num_words` DATA_SIZE-bit words on a valid/ready stream, assigns each an incrementing address from `base_addr`, and drives the write side of `write_mem_controller`. It holds each word until the controller accepts it with `out_ready`, then signals completion. It sits between the DMA/pixel-packer stream and `write_mem_controller`.

## Interface
- `ADD_SIZE`, 12, memory address width.
- `DATA_SIZE`, 108, memory word width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a load; sampled only in IDLE.
- `abort`  in  1  cancel the current load; takes priority over everything except `rst`.
- `base_addr`  in  ADD_SIZE  first write address; latched on accepted `start`.
- `num_words`  in  ADD_SIZE+1  words to load, 0..2^ADD_SIZE; latched on accepted `start`.
- `s_valid`  in  1  stream word available.
- `s_data`  in  DATA_SIZE  stream word.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `write_en`  out  1  write request to controller; always equal to `in_valid`.
- `in_valid`  out  1  `address_in`/`dataIn` valid.
- `address_in`  out  ADD_SIZE  write address.
- `dataIn`  out  DATA_SIZE  write data.
- `out_ready`  in  1  controller accepts the current word.
- `busy`  out  1  load in progress (LOAD or DRAIN).
- `done`  out  1  one-cycle pulse: all words written.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: `start`=1 latches `base_addr` into the address counter and `num_words` into the fetch and write counters. Next state is LOAD, or DONE if `num_words`=0. `start` in any other state is ignored.
- LOAD: uses a single holding register (`address_in`, `dataIn`, `in_valid`).
  - `s_ready` = fetch counter ≠ 0 AND (`in_valid`=0 OR `out_ready`=1).
  - Stream accept (`s_valid & s_ready`): next cycle the holding register gets `s_data` and the current address, `in_valid`=1. The address counter increments and the fetch counter decrements.
  - Controller accept (`in_valid & out_ready`): the write counter decrements. If no stream accept happens in the same cycle, `in_valid` clears next cycle.
  - A simultaneous stream accept and controller accept replaces the held word with no bubble.
  - When the fetch counter reaches 0, go to DRAIN.
- DRAIN: `s_ready`=0. Hold the last word until `out_ready`, then go to DONE. If the last word is accepted in the same cycle the fetch counter hits 0, go directly from LOAD to DONE.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^ADD_SIZE: 12'hFFF+1 wraps to 12'h000 with no error flag.
- `num_words`=2^ADD_SIZE writes every address exactly once.
- `abort` (any state except IDLE): next cycle the FSM is IDLE, `in_valid`=0, the held word is dropped, and `done` is not pulsed. A word already accepted by the controller stays written.
- `in_valid` and the held data/address never change while `in_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `s_ready`=0, `write_en`=0, `in_valid`=0, `address_in`=0, `dataIn`=0, `busy`=0, `done`=0; FSM in IDLE; all counters 0.
- `start` at cycle n:
  - `busy`=1 and `s_ready`=1 from cycle n+1.
  - With `num_words`=0: `done`=1 at n+1 and `busy` stays 0.
- Latency: a stream accept at cycle k puts the word on `in_valid`/`address_in`/`dataIn` at k+1.
- Throughput: one word per cycle with `s_valid` and `out_ready` held high.
- Final controller accept at cycle m: `done`=1 at m+1 and `busy`=0 at m+1.
- With continuous flow for N words, `done` asserts N+2 cycles after `start`.
- `s_ready` is combinational from state, counters and `out_ready`. All other outputs are registered.

## Test plan
- Basic load: `base_addr`=0x000, `num_words`=4, stream 0x0, 0x115, 0x117, 0x120, `out_ready`=1.
  - Writes (0x000,0x0), (0x001,0x115), (0x002,0x117), (0x003,0x120) on consecutive cycles.
  - `done` pulses at cycle 6 after `start`.
- Backpressure: as above, but `out_ready`=0 for 3 cycles while the second word is held.
  - `address_in`=0x001 and `dataIn`=0x115 stay stable.
  - `s_ready`=0 during the stall; no word is lost or duplicated.
- Wrap-around: `base_addr`=0xFFE, `num_words`=3.
  - Addresses 0xFFE, 0xFFF, 0x000; `done` pulses once.
- Zero-length load: `num_words`=0.
  - `done`=1 the cycle after `start`; `in_valid`, `s_ready` and `busy` never assert.
- Abort mid-load: `num_words`=8, assert `abort` after 3 words are accepted.
  - Next cycle: `in_valid`=0, `busy`=0, FSM in IDLE; no `done`.
  - A following `start` with `base_addr`=0x010 writes from 0x010.
- Reset mid-operation and ignored `start`:
  - `rst` during DRAIN forces all outputs to their reset values the next cycle.
  - A `start` pulse while `busy`=1 does not change the latched `base_addr`/`num_words`.
